// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue gate for a multi-pipe EXE stage.
// Tracks pending GPR writes (RAW/WAW), reserves writeback slots for the
// fixed-latency pipes and a single outstanding op for the variable pipe.
// Optional build macro ISSUE_WB_BYPASS_EN: hazard check sees the same-cycle
// writeback clear, so a dependent issues in its producer's WB cycle.
module issue_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_PIPES = 4,
  parameter int MAX_LAT   = 8,
  parameter logic [NUM_PIPES*4-1:0] PIPE_LAT = {4'd0, 4'd3, 4'd2, 4'd1},
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RW-1:0]        in_rd,
  input  logic [RW-1:0]        in_rs1,
  input  logic [RW-1:0]        in_rs2,
  input  logic                 in_rd_wr,
  input  logic [NUM_PIPES-1:0] in_pipe,
  output logic [NUM_PIPES-1:0] issue_valid,
  output logic [RW-1:0]        issue_rd,
  input  logic                 wb_en,
  input  logic [RW-1:0]        wb_rd,
  input  logic                 var_done,
  input  logic                 flush,
  output logic [31:0]          stall_cnt
);

  if ((1 << RW) != NUM_REGS) begin : g_regs_err
    $error("issue_scoreboard: NUM_REGS must be a power of two");
  end

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [MAX_LAT-1:0]   ring_q, ring_d;
  logic                 busy_q, busy_d;
  logic [NUM_PIPES-1:0] issue_valid_q, issue_valid_d;
  logic [RW-1:0]        issue_rd_q, issue_rd_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;

  // Ring as it will look after this cycle's shift; new reservations land here.
  logic [MAX_LAT-1:0]   ring_sh;
  assign ring_sh = ring_q >> 1;

  logic [NUM_PIPES-1:0] pipe_wb_conf;
  logic [NUM_PIPES-1:0] pipe_var;
  logic [MAX_LAT-1:0]   pipe_slot [NUM_PIPES];

  // Per-pipe constants: a fixed pipe of latency L owns post-shift slot L-1.
  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
    localparam int LAT    = int'(PIPE_LAT[p*4 +: 4]);
    localparam bit IS_VAR = (LAT == 0);
    localparam int SLOT   = IS_VAR ? 0 : LAT - 1;
    if (LAT > MAX_LAT) begin : g_lat_err
      $error("issue_scoreboard: PIPE_LAT exceeds MAX_LAT");
    end
    assign pipe_var[p]     = in_pipe[p] && IS_VAR;
    assign pipe_wb_conf[p] = in_pipe[p] && !IS_VAR && in_rd_wr && ring_sh[SLOT];
    assign pipe_slot[p]    = (in_pipe[p] && !IS_VAR) ? (MAX_LAT'(1) << SLOT) : '0;
  end

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] pend_eff;
  logic [MAX_LAT-1:0]  slot_set;
  logic                raw_waw, wb_conf, busy_conf, is_nop, accept;

  // Hazard evaluation and the accept decision for the head instruction.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wb_mask = '0;
    if (wb_en) wb_mask[wb_rd] = 1'b1;
`ifdef ISSUE_WB_BYPASS_EN
    pend_eff = pending_q & ~wb_mask;
`else
    pend_eff = pending_q;
`endif
    slot_set = '0;
    for (int p = 0; p < NUM_PIPES; p++) slot_set |= pipe_slot[p];
    raw_waw   = pend_eff[in_rs1] || pend_eff[in_rs2] || (in_rd_wr && pend_eff[in_rd]);
    wb_conf   = |pipe_wb_conf;
    // A var_done this cycle frees the variable pipe for a back-to-back op.
    busy_conf = (|pipe_var) && busy_q && !var_done;
    is_nop    = ~|in_pipe;
    in_ready  = in_valid && !rst && !flush &&
                (is_nop || !(raw_waw || wb_conf || busy_conf));
    accept    = in_ready;
  end

  // Next-state for scoreboard state, issue outputs and stall counter.
  always_comb begin
    pending_d     = pending_q & ~wb_mask;
    ring_d        = ring_sh;
    busy_d        = busy_q && !var_done;
    issue_valid_d = '0;
    issue_rd_d    = issue_rd_q;
    if (accept && !is_nop) begin
      issue_valid_d = in_pipe;
      issue_rd_d    = in_rd;
      // Set after clear: a same-cycle writeback of this rd leaves it pending.
      if (in_rd_wr && (in_rd != '0)) begin
        pending_d[in_rd] = 1'b1;
        ring_d           = ring_d | slot_set;
      end
      if (|pipe_var) busy_d = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
      ring_d    = '0;
      busy_d    = 1'b0;
    end
    pending_d[0] = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      pending_q     <= '0;
      ring_q        <= '0;
      busy_q        <= 1'b0;
      issue_valid_q <= '0;
      issue_rd_q    <= '0;
      stall_cnt_q   <= '0;
    end else begin
      pending_q     <= pending_d;
      ring_q        <= ring_d;
      busy_q        <= busy_d;
      issue_valid_q <= issue_valid_d;
      issue_rd_q    <= issue_rd_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_rd    = issue_rd_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed, table-driven bench for issue_scoreboard (default parameters).
module tb_issue_scoreboard;

  localparam logic [3:0] ALU = 4'b0001;  // lat 1
  localparam logic [3:0] P1  = 4'b0010;  // lat 2
  localparam logic [3:0] MUL = 4'b0100;  // lat 3
  localparam logic [3:0] DIV = 4'b1000;  // variable

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rd_wr, wb_en, var_done, flush;
  logic [4:0]  in_rd, in_rs1, in_rs2, wb_rd, issue_rd;
  logic [3:0]  in_pipe, issue_valid;
  logic [31:0] stall_cnt;

  issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd_wr(in_rd_wr), .in_pipe(in_pipe),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_rd(wb_rd),
    .var_done(var_done), .flush(flush),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] pipe;
    logic [4:0] rd, rs1, rs2;
    logic       wr;
    logic       wbe;
    logic [4:0] wbrd;
    logic       vd, fl;
    logic       ready;
    logic [3:0] iv;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_stall = '0;
  logic [4:0]  exp_ird = '0;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [3:0] pipe, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic wr, logic wbe, logic [4:0] wbrd,
                              logic vd, logic fl, logic ready, logic [3:0] iv);
    vec_t t;
    t.v = v; t.pipe = pipe; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.wr = wr;
    t.wbe = wbe; t.wbrd = wbrd; t.vd = vd; t.fl = fl; t.ready = ready; t.iv = iv;
    return t;
  endfunction

  function automatic vec_t idle(logic wbe, logic [4:0] wbrd, logic vd);
    return mk(1'b0, 4'b0, 5'd0, 5'd0, 5'd0, 1'b0, wbe, wbrd, vd, 1'b0, 1'b0, 4'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after negedge, check in_ready, then registered outputs after posedge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = 1'b0;
    in_valid = t.v; in_pipe = t.pipe; in_rd = t.rd; in_rs1 = t.rs1; in_rs2 = t.rs2;
    in_rd_wr = t.wr; wb_en = t.wbe; wb_rd = t.wbrd; var_done = t.vd; flush = t.fl;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(t.ready));
    if (t.v && !t.ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    if (t.ready && t.pipe != 4'b0) exp_ird = t.rd;
    @(posedge clk);
    #1;
    check({tag, ".issue_valid"}, 32'(issue_valid), 32'(t.iv));
    check({tag, ".issue_rd"}, 32'(issue_rd), 32'(exp_ird));
    check({tag, ".stall_cnt"}, stall_cnt, exp_stall);
  endtask

  initial begin
    logic [31:0] base;
    // Reset with a valid head and every other control asserted: rst dominates.
    rst = 1'b1; in_valid = 1'b1; in_pipe = ALU; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_rd_wr = 1'b1; wb_en = 1'b1; wb_rd = 5'd1; var_done = 1'b1; flush = 1'b1;
    @(negedge clk); #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst.issue_valid", 32'(issue_valid), 32'd0);
    check("rst.issue_rd", 32'(issue_rd), 32'd0);
    check("rst.stall_cnt", stall_cnt, 32'd0);

    // MUL rd=5 then dependent ALU rs1=5 waiting for WB of r5.
    tbl.push_back(mk(1, MUL, 5, 1, 2, 1, 0, 0, 0, 0, 1, MUL));
    tbl.push_back(mk(1, ALU, 6, 5, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, ALU, 6, 5, 0, 1, 0, 0, 0, 0, 0, 0));
`ifdef ISSUE_WB_BYPASS_EN
    tbl.push_back(mk(1, ALU, 6, 5, 0, 1, 1, 5, 0, 0, 1, ALU));
    tbl.push_back(idle(0, 0, 0));
`else
    tbl.push_back(mk(1, ALU, 6, 5, 0, 1, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk(1, ALU, 6, 5, 0, 1, 0, 0, 0, 0, 1, ALU));
`endif
    tbl.push_back(idle(1, 6, 0));
    // WB slot collision: MUL at cycle 0, ALU at cycle 2 stalls, accepted cycle 3.
    tbl.push_back(mk(1, MUL, 3, 0, 0, 1, 0, 0, 0, 0, 1, MUL));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(1, ALU, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, ALU, 4, 0, 0, 1, 0, 0, 0, 0, 1, ALU));
    tbl.push_back(idle(1, 3, 0));
    tbl.push_back(idle(1, 4, 0));
    // Variable pipe: second DIV waits for var_done, accepted in that cycle, busy stays set.
    tbl.push_back(mk(1, DIV, 7, 0, 0, 1, 0, 0, 0, 0, 1, DIV));
    tbl.push_back(mk(1, DIV, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, DIV, 8, 1, 0, 1, 0, 0, 1, 0, 1, DIV));
    tbl.push_back(mk(1, DIV, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 7, 1));
    tbl.push_back(idle(1, 8, 0));
    // Flush clears pending[9] and busy: dependent ALU and new DIV go straight through.
    tbl.push_back(mk(1, MUL, 9, 0, 0, 1, 0, 0, 0, 0, 1, MUL));
    tbl.push_back(mk(1, DIV, 10, 0, 0, 1, 0, 0, 0, 0, 1, DIV));
    tbl.push_back(mk(1, ALU, 11, 9, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, ALU, 11, 9, 0, 1, 0, 0, 0, 0, 1, ALU));
    tbl.push_back(mk(1, DIV, 12, 0, 0, 1, 0, 0, 0, 0, 1, DIV));
    tbl.push_back(idle(1, 11, 1));
    tbl.push_back(idle(1, 12, 0));
    // r0 destinations and sources never stall.
    tbl.push_back(mk(1, ALU, 0, 0, 0, 1, 0, 0, 0, 0, 1, ALU));
    tbl.push_back(mk(1, ALU, 0, 0, 0, 1, 0, 0, 0, 0, 1, ALU));
    tbl.push_back(mk(1, MUL, 0, 0, 0, 1, 0, 0, 0, 0, 1, MUL));
    // NOP ignores hazards; real dependent still stalls.
    tbl.push_back(mk(1, MUL, 14, 0, 0, 1, 0, 0, 0, 0, 1, MUL));
    tbl.push_back(mk(1, 4'b0, 14, 14, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, ALU, 15, 14, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 14, 0));
    tbl.push_back(idle(0, 0, 0));
    // Non-writing op ignores the slot collision.
    tbl.push_back(mk(1, MUL, 16, 0, 0, 1, 0, 0, 0, 0, 1, MUL));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(1, ALU, 17, 0, 0, 0, 0, 0, 0, 0, 1, ALU));
    tbl.push_back(idle(1, 16, 0));
    // Lat-2 pipe collides with a MUL issued one cycle earlier.
    tbl.push_back(mk(1, MUL, 18, 0, 0, 1, 0, 0, 0, 0, 1, MUL));
    tbl.push_back(mk(1, P1, 19, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, P1, 19, 0, 0, 1, 0, 0, 0, 0, 1, P1));
    tbl.push_back(idle(1, 18, 0));
    tbl.push_back(idle(1, 19, 0));
    // Same-cycle set and WB clear of r22 resolves to set.
    tbl.push_back(mk(1, ALU, 22, 0, 0, 1, 1, 22, 0, 0, 1, ALU));
    tbl.push_back(mk(1, ALU, 23, 22, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 22, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // Ten cycles of a permanent hazard add exactly ten to stall_cnt.
    apply(mk(1, MUL, 20, 0, 0, 1, 0, 0, 0, 0, 1, MUL), "seq_mul20");
    base = exp_stall;
    for (int i = 0; i < 10; i++)
      apply(mk(1, ALU, 21, 20, 0, 1, 0, 0, 0, 0, 0, 0), $sformatf("hold%0d", i));
    check("stall10", stall_cnt - base, 32'd10);

    // Preload near saturation and keep stalling: counter pins at all-ones.
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++)
      apply(mk(1, ALU, 21, 20, 0, 1, 0, 0, 0, 0, 0, 0), $sformatf("sat%0d", i));
    check("sat_final", stall_cnt, 32'hFFFF_FFFF);

    // Reset mid-stall with wb/flush/var_done asserted, then pending is gone.
    @(negedge clk);
    rst = 1'b1; wb_en = 1'b1; wb_rd = 5'd3; flush = 1'b1; var_done = 1'b1;
    #1;
    check("rst2.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst2.stall_cnt", stall_cnt, 32'd0);
    check("rst2.issue_valid", 32'(issue_valid), 32'd0);
    check("rst2.issue_rd", 32'(issue_rd), 32'd0);
    exp_stall = '0;
    exp_ird = '0;
    apply(mk(1, ALU, 21, 20, 0, 1, 0, 0, 0, 0, 1, ALU), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
